display_scan_controller: RTL
============================

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports SHALL be clk and rst_n.
REQ-002 Parameter PRESCALE, default 16'd50000, SHALL set the digit on-time in clk cycles (legal 1..65535).
REQ-003 Parameter BLANK, default 8'd8, SHALL set the inter-digit blanking time in clk cycles (legal 1..255).
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 enable  in  1  level; 1 = scan the display, 0 = display dark.
REQ-007 load  in  1  single-cycle strobe capturing load_data.
REQ-008 load_data  in  12  digit k occupies bits [3k+2:3k] as {selector, bit1, bit0}, k=0..3.
REQ-009 dec_selector  out  1  drives the shared segment decoder selector input.
REQ-010 dec_bit1, dec_bit0  out  1 each  drive the shared decoder entry bits.
REQ-011 digit_en_n  out  4  active-low digit enables; bit k lights digit k.
REQ-012 load_pending  out  1  shadow data is waiting for a frame boundary.
REQ-013 frame_done  out  1  one-cycle pulse at the end of each full 4-digit scan.

Function
REQ-014 FSM states SHALL be IDLE, BLANK, SHOW; a 2-bit digit index idx and a 16-bit cycle counter cnt SHALL be kept.
REQ-015 IDLE: digit_en_n=4'b1111, decoder outputs 0, idx=0, cnt=0; enable=1 -> BLANK next cycle.
REQ-016 BLANK: digit_en_n=4'b1111, decoder outputs = active code of digit idx; after BLANK cycles -> SHOW.
REQ-017 SHOW: digit_en_n has only bit idx low, decoder outputs = active code of digit idx; after PRESCALE cycles -> BLANK with idx+1, wrapping 3->0.
REQ-018 Frame boundary SHALL be the SHOW->BLANK transition with idx=3; frame_done SHALL be 1 in that exact cycle only.
REQ-019 Frame period SHALL be exactly 4*(BLANK+PRESCALE) cycles; cnt SHALL reset to 0 on every state change.
REQ-020 load=1 SHALL copy load_data into a 12-bit shadow register and set load_pending; a later load before the boundary overwrites the shadow.
REQ-021 At a frame boundary with load_pending=1, shadow SHALL move to the active register and load_pending SHALL clear.
REQ-022 load coincident with a frame boundary SHALL bypass: load_data goes directly to active, load_pending stays 0.
REQ-023 load while in IDLE SHALL update active immediately; load_pending stays 0.
REQ-024 enable=0 in BLANK or SHOW SHALL force IDLE next cycle (dark, idx=0, cnt=0); load_pending and shadow SHALL be retained.
REQ-025 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, digit_en_n=4'b1111, decoder outputs 0, load_pending=0, frame_done=0, active=shadow=12'h000, idx=0, cnt=0.
REQ-027 Reset mid-scan SHALL discard the shadow; the first scan after release starts at digit 0 with BLANK.

Structure
REQ-028 State encodings (IDLE=2'd0, BLANK=2'd1, SHOW=2'd2), DIGITS=4 and the 3-bit digit field width SHALL live in the shared display constants include file.
REQ-029 The cycle counter with terminal-count compare SHALL be one sub-module, scan_timer.
REQ-030 The segment decoder SHALL be instantiated outside this block; this block drives only its inputs.

Verification (PRESCALE=4, BLANK=2)
REQ-031 Reset release, enable=1 -> 2 cycles digit_en_n=1111, then 4 cycles 1110, then 2 cycles 1111, then 4 cycles 1101; frame_done pulse at cycle 24.
REQ-032 IDLE load 12'b101_011_000_111 -> digit 0 shows {1,1,1}, digit 3 shows {1,0,1} on the first scan.
REQ-033 Mid-frame load 12'hFFF -> load_pending=1, old codes finish the frame, new codes from the next digit 0, load_pending=0 after the boundary.
REQ-034 load in the frame_done cycle -> load_pending never rises, new codes appear in the next digit 0.
REQ-035 enable dropped during SHOW of digit 2 -> digit_en_n=1111 next cycle; re-enable restarts at BLANK of digit 0.
REQ-036 rst_n pulsed low mid-SHOW with load_pending=1 -> all outputs at reset values at once, load_pending=0.

Source files
------------

// File: rtl/display_scan_controller_pkg.sv
// Shared constants for the display scan controller: FSM state encoding,
// digit count, digit field width and helpers to pick a digit's code and
// its active-low enable pattern out of a packed display word.
package display_scan_controller_pkg;

   localparam int DIGITS  = 4;
   localparam int DIGIT_W = 3;
   localparam int IDX_W   = 2;
   localparam int CNT_W   = 16;
   localparam int DATA_W  = DIGITS * DIGIT_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } scan_state_t;

   function automatic logic [DIGIT_W-1:0] digit_code(input logic [DATA_W-1:0] word,
                                                      input logic [IDX_W-1:0]  k);
      logic [DIGIT_W-1:0] c;
      c = word[DIGIT_W-1:0];
      for (int i = 0; i < DIGITS; i++) begin
         if (k == IDX_W'(i)) c = word[DIGIT_W*i +: DIGIT_W];
      end
      return c;
   endfunction

   function automatic logic [DIGITS-1:0] digit_enable_n(input logic [IDX_W-1:0] k);
      logic [DIGITS-1:0] one;
      one = DIGITS'(1);
      return ~(one << k);
   endfunction

endpackage

// File: rtl/display_scan_controller_timer.sv
// scan_timer: per-state cycle counter with terminal-count compare.
//   clk, rst_n  : clock, async active-low reset
//   clear_i     : restart from 0 on the next edge (state change / idle)
//   tc_val_i    : length of the current state in cycles (>= 1)
//   cnt_next_o  : value the counter takes on the next edge
//   tc_o        : current cycle is the last one of the state
module scan_timer
   import display_scan_controller_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic [CNT_W-1:0] tc_val_i,
   output logic [CNT_W-1:0] cnt_next_o,
   output logic             tc_o
);

   logic [CNT_W-1:0] cnt_q;

   assign cnt_next_o = clear_i ? '0 : cnt_q + CNT_W'(1);
   assign tc_o       = (cnt_q == tc_val_i - CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_next_o;
   end

endmodule

// File: rtl/display_scan_controller.sv
// Multiplexed 4-digit display scanner. Drives the inputs of an external
// shared segment decoder and the active-low digit enables, with a blanking
// gap between digits. New display data is double-buffered and only swapped
// in at a frame boundary so a frame never mixes old and new codes.
//   clk, rst_n                        : clock, async active-low reset
//   enable                            : 1 = scan, 0 = dark
//   load, load_data[11:0]             : strobe + data, digit k at [3k+2:3k]
//   dec_selector, dec_bit1, dec_bit0  : decoder inputs for the lit digit
//   digit_en_n[3:0]                   : active-low digit enables
//   load_pending                      : shadow data waiting for the boundary
//   frame_done                        : high during the last SHOW cycle of digit 3
//
// state | meaning
// IDLE  | dark, idx=0, counter held at 0
// BLANK | all digits off, decoder already presents digit idx
// SHOW  | digit idx lit for PRESCALE cycles
module display_scan_controller
   import display_scan_controller_pkg::*;
#(
   parameter logic [15:0] PRESCALE = 16'd50000,
   parameter logic [7:0]  BLANK    = 8'd8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   output logic              dec_selector,
   output logic              dec_bit1,
   output logic              dec_bit0,
   output logic [DIGITS-1:0] digit_en_n,
   output logic              load_pending,
   output logic              frame_done
);

   scan_state_t       state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] active_q, active_d;
   logic [DATA_W-1:0] shadow_q, shadow_d;
   logic              pending_q, pending_d;
   logic [DIGIT_W-1:0] dec_q, dec_d;
   logic [DIGITS-1:0] en_n_q, en_n_d;
   logic              done_q, done_d;

   logic              tc;
   logic              timer_clear;
   logic [CNT_W-1:0]  tc_val;
   logic [CNT_W-1:0]  cnt_next;
   logic              boundary;

   assign tc_val      = (state_q == ST_SHOW) ? PRESCALE : CNT_W'(BLANK);
   assign timer_clear = (state_d != state_q) || (state_q == ST_IDLE);
   assign boundary    = (state_q == ST_SHOW) && (idx_q == IDX_W'(DIGITS-1)) && tc && enable;

   scan_timer u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (timer_clear),
      .tc_val_i   (tc_val),
      .cnt_next_o (cnt_next),
      .tc_o       (tc)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         ST_IDLE: begin
            idx_d = '0;
            if (enable) state_d = ST_BLANK;
         end
         ST_BLANK: begin
            if (!enable) begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end else if (tc) begin
               state_d = ST_SHOW;
            end
         end
         ST_SHOW: begin
            if (!enable) begin
               state_d = ST_IDLE;
               idx_d   = '0;
            end else if (tc) begin
               state_d = ST_BLANK;
               idx_d   = idx_q + IDX_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // A load landing on the boundary edge wins over any older shadow data.
   always_comb begin
      active_d  = active_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      if (load && boundary) begin
         active_d  = load_data;
         pending_d = 1'b0;
      end else if (load && state_q == ST_IDLE) begin
         active_d = load_data;
      end else if (load) begin
         shadow_d  = load_data;
         pending_d = 1'b1;
      end else if (boundary && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
   end

   // Outputs are decoded from next-state values and registered, so they line
   // up with the state register and never see input glitches.
   always_comb begin
      dec_d  = '0;
      en_n_d = '1;
      if (state_d != ST_IDLE) dec_d = digit_code(active_d, idx_d);
      if (state_d == ST_SHOW) en_n_d = digit_enable_n(idx_d);
      done_d = (state_d == ST_SHOW) && (idx_d == IDX_W'(DIGITS-1)) &&
               (cnt_next == PRESCALE - CNT_W'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         active_q  <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         dec_q     <= '0;
         en_n_q    <= '1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         dec_q     <= dec_d;
         en_n_q    <= en_n_d;
         done_q    <= done_d;
      end
   end

   assign dec_selector = dec_q[2];
   assign dec_bit1     = dec_q[1];
   assign dec_bit0     = dec_q[0];
   assign digit_en_n   = en_n_q;
   assign load_pending = pending_q;
   assign frame_done   = done_q;

endmodule
